// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge port used by the memory stage.
// master = the pipeline stage issuing accesses, slave = the memory.
interface memory_stage_if;
  logic        DmemReq;
  logic        DmemWe;
  logic [31:0] DmemAddr;
  logic [31:0] DmemWdata;
  logic [3:0]  DmemBe;
  logic        DmemAck;
  logic [31:0] DmemRdata;

  modport master (
    output DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
    input  DmemAck, DmemRdata
  );

  modport slave (
    input  DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
    output DmemAck, DmemRdata
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage with MEM/WB register: issues loads/stores over a
// req/ack data-memory port and stalls earlier stages while an access is outstanding.
module memory_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [31:0]           ALUResultM,
  input  logic [31:0]           WriteDataM,
  input  logic [4:0]            RdM,
  input  logic                  MemTypeM,
  memory_stage_if.master        dmem,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic [4:0]            RdW,
  output logic [31:0]           ResultW,
  output logic                  MemErr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [7:0]  timeout_cnt;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic [31:0] read_data_q;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic        result_src_w;
  logic        mem_op;

  // Byte loads pick the addressed lane and zero-extend it.
  function automatic logic [31:0] format_load(input logic [31:0] raw,
                                              input logic        is_byte,
                                              input logic [1:0]  lane);
    logic [31:0] shifted;
    shifted = raw >> {lane, 3'b000};
    return is_byte ? {24'b0, shifted[7:0]} : raw;
  endfunction

  assign mem_op  = MemWriteM | ResultSrcM;
  assign StallM  = ((state == IDLE) && mem_op) || (state == REQ);
  assign ResultW = result_src_w ? read_data_w : alu_result_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dmem.DmemReq   <= 1'b0;
      dmem.DmemWe    <= 1'b0;
      dmem.DmemAddr  <= '0;
      dmem.DmemWdata <= '0;
      dmem.DmemBe    <= '0;
      timeout_cnt    <= '0;
      byte_q         <= 1'b0;
      lane_q         <= '0;
      read_data_q    <= '0;
      RegWriteW      <= 1'b0;
      RdW            <= '0;
      alu_result_w   <= '0;
      read_data_w    <= '0;
      result_src_w   <= 1'b0;
      MemErr         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state          <= REQ;
            dmem.DmemReq   <= 1'b1;
            dmem.DmemWe    <= MemWriteM;
            dmem.DmemAddr  <= {ALUResultM[31:2], 2'b00};
            dmem.DmemBe    <= MemTypeM ? (4'b0001 << ALUResultM[1:0]) : 4'b1111;
            dmem.DmemWdata <= MemTypeM ? {4{WriteDataM[7:0]}} : WriteDataM;
            byte_q         <= MemTypeM;
            lane_q         <= ALUResultM[1:0];
            timeout_cnt    <= '0;
            RegWriteW      <= 1'b0;
          end else begin
            RegWriteW    <= RegWriteM;
            RdW          <= RdM;
            alu_result_w <= ALUResultM;
            result_src_w <= ResultSrcM;
          end
        end

        REQ: begin
          RegWriteW <= 1'b0;
          if (dmem.DmemAck) begin
            read_data_q  <= format_load(dmem.DmemRdata, byte_q, lane_q);
            dmem.DmemReq <= 1'b0;
            state        <= DONE;
          end else if (timeout_cnt == 8'(ACK_TIMEOUT - 1)) begin
            // Abandoned access: flag it and write back zero.
            MemErr       <= 1'b1;
            read_data_q  <= '0;
            dmem.DmemReq <= 1'b0;
            state        <= DONE;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
        end

        DONE: begin
          state        <= IDLE;
          RegWriteW    <= RegWriteM & ~MemWriteM;
          RdW          <= RdM;
          alu_result_w <= ALUResultM;
          result_src_w <= ResultSrcM & ~MemWriteM;
          read_data_w  <= read_data_q;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a transaction-level schedule model
// predicts every output per cycle, plus literal checks of the test-plan values.
module tb_memory_stage;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, ResultSrcM, MemWriteM, MemTypeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;
  logic        StallM, RegWriteW, MemErr;
  logic [4:0]  RdW;
  logic [31:0] ResultW;

  memory_stage_if dmem_bus();

  memory_stage #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .MemTypeM   (MemTypeM),
    .dmem       (dmem_bus),
    .StallM     (StallM),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .MemErr     (MemErr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model expectations for the current cycle
  logic        exp_stall = 0, exp_req = 0, exp_we = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;
  logic        exp_regwrite_w = 0;
  logic [4:0]  exp_rd_w = 0;
  logic [31:0] exp_result_w = 0;
  logic        exp_mem_err = 0;

  // Effects scheduled for the next clock edge
  bit          pend_w = 0, pend_err = 0, pend_rst = 0;
  logic        pend_rw = 0;
  logic [4:0]  pend_rd = 0;
  logic [31:0] pend_res = 0;

  // Observations for the literal checks
  int          stall_seen = 0, req_seen = 0, rw_pulses = 0;
  logic [31:0] seen_addr = 0, seen_wdata = 0;
  logic [3:0]  seen_be = 0;
  logic        snap_regwrite_w = 0, snap_mem_err = 0;
  logic [4:0]  snap_rd_w = 0;
  logic [31:0] snap_result_w = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("StallM", StallM, exp_stall);
      checkOutput("DmemReq", dmem_bus.DmemReq, exp_req);
      if (exp_req) begin
        checkOutput("DmemAddr", dmem_bus.DmemAddr, exp_addr);
        checkOutput("DmemBe", dmem_bus.DmemBe, exp_be);
        checkOutput("DmemWdata", dmem_bus.DmemWdata, exp_wdata);
        checkOutput("DmemWe", dmem_bus.DmemWe, exp_we);
      end
      checkOutput("RegWriteW", RegWriteW, exp_regwrite_w);
      checkOutput("RdW", RdW, exp_rd_w);
      checkOutput("ResultW", ResultW, exp_result_w);
      checkOutput("MemErr", MemErr, exp_mem_err);
    end
  end

  // Advance one clock and apply the edge's scheduled effects to the model.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    if (pend_rst) begin
      exp_regwrite_w = 0; exp_rd_w = 0; exp_result_w = 0; exp_mem_err = 0;
    end else begin
      if (pend_w) begin
        exp_regwrite_w = pend_rw; exp_rd_w = pend_rd; exp_result_w = pend_res;
      end else begin
        exp_regwrite_w = 0;
      end
      if (pend_err) exp_mem_err = 1;
    end
    pend_w = 0; pend_err = 0; pend_rst = 0;
    snap_regwrite_w = RegWriteW; snap_rd_w = RdW;
    snap_result_w = ResultW; snap_mem_err = MemErr;
    if (check_en && RegWriteW) rw_pulses++;
    dmem_bus.DmemAck = 1'b0;
  endtask

  task automatic sampleBus();
    #1;
    if (StallM) stall_seen++;
    if (dmem_bus.DmemReq) begin
      if (req_seen == 0) begin
        seen_addr = dmem_bus.DmemAddr; seen_be = dmem_bus.DmemBe;
        seen_wdata = dmem_bus.DmemWdata;
      end
      req_seen++;
    end
  endtask

  task automatic driveM(input logic rw, input logic rs, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic mt);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; RdM = rd; MemTypeM = mt;
  endtask

  // One instruction in M; ack_k = REQ cycle carrying the ack, 0 = never acked.
  task automatic applyStimulus(input logic rw, input logic rs, input logic mw,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] rd, input logic mt,
                               input int ack_k, input logic [31:0] rdata);
    logic [31:0] load_val, res;
    int lane, n_req;
    lane = int'(alu[1:0]);
    if (ack_k == 0) load_val = 0;
    else if (mt) load_val = (rdata >> (lane * 8)) & 32'hFF;
    else load_val = rdata;
    res = (rs && !mw) ? load_val : alu;
    stall_seen = 0; req_seen = 0;

    nextCycle();
    driveM(rw, rs, mw, alu, wd, rd, mt);
    dmem_bus.DmemRdata = rdata;
    exp_req = 0;
    if (!(rs || mw)) begin
      exp_stall = 0;
      pend_w = 1; pend_rw = rw; pend_rd = rd; pend_res = res;
      sampleBus();
    end else begin
      exp_stall = 1;
      sampleBus();
      n_req = (ack_k == 0) ? ACK_TIMEOUT : ack_k;
      for (int i = 1; i <= n_req; i++) begin
        nextCycle();
        exp_stall = 1; exp_req = 1; exp_we = mw;
        exp_addr  = alu & 32'hFFFF_FFFC;
        exp_be    = mt ? 4'(1 << lane) : 4'hF;
        exp_wdata = mt ? {4{wd[7:0]}} : wd;
        dmem_bus.DmemAck = (i == ack_k);
        if (ack_k == 0 && i == n_req) pend_err = 1;
        sampleBus();
      end
      nextCycle();
      exp_stall = 0; exp_req = 0;
      pend_w = 1; pend_rw = rw & ~mw; pend_rd = rd; pend_res = res;
      sampleBus();
    end
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
  endtask

  int s_cnt, r_cnt, p0;
  logic [31:0] a_seen, w_seen;
  logic [3:0]  b_seen;

  initial begin
    rst = 1'b1;
    driveM(0, 0, 0, 0, 0, 0, 0);
    dmem_bus.DmemAck = 1'b0;
    dmem_bus.DmemRdata = 32'h0;
    pend_rst = 1;
    nextCycle();
    check_en = 1;
    exp_stall = 0; exp_req = 0; pend_rst = 1;
    checkOutput("reset_DmemReq", dmem_bus.DmemReq, 0);
    checkOutput("reset_RdW", RdW, 0);
    nextCycle();
    rst = 1'b0;
    exp_stall = 0; exp_req = 0;
    pend_w = 1; pend_rw = 0; pend_rd = 0; pend_res = 0;

    // ALU op
    applyStimulus(1, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0);
    s_cnt = stall_seen;
    nop();
    checkOutput("alu_stall_cycles", s_cnt, 0);
    checkOutput("alu_RegWriteW", snap_regwrite_w, 1);
    checkOutput("alu_RdW", snap_rd_w, 5);
    checkOutput("alu_ResultW", snap_result_w, 32'h1234);

    // Word load, ack in 3rd REQ cycle
    p0 = rw_pulses;
    applyStimulus(1, 1, 0, 32'h100, 32'h0, 5'd7, 0, 3, 32'hCAFEBABE);
    s_cnt = stall_seen; b_seen = seen_be;
    nop();
    checkOutput("wload_stall_cycles", s_cnt, 4);
    checkOutput("wload_DmemBe", b_seen, 4'b1111);
    checkOutput("wload_ResultW", snap_result_w, 32'hCAFEBABE);
    checkOutput("wload_pulses", rw_pulses - p0, 1);

    // Byte store of 0xA5 to 0x203, ack in 1st REQ cycle
    applyStimulus(0, 0, 1, 32'h203, 32'h0000_00A5, 5'd0, 1, 1, 32'h0);
    a_seen = seen_addr; b_seen = seen_be; w_seen = seen_wdata; s_cnt = stall_seen;
    nop();
    checkOutput("bstore_addr", a_seen, 32'h200);
    checkOutput("bstore_be", b_seen, 4'b1000);
    checkOutput("bstore_wdata", w_seen, 32'hA5A5A5A5);
    checkOutput("bstore_stall_cycles", s_cnt, 2);
    checkOutput("bstore_RegWriteW", snap_regwrite_w, 0);

    // Byte load from 0x301
    applyStimulus(1, 1, 0, 32'h301, 32'h0, 5'd9, 1, 2, 32'h11F2_3344);
    nop();
    checkOutput("bload_ResultW", snap_result_w, 32'h0000_0033);

    // Back-to-back: word store then misaligned word load, then byte load lane 2
    applyStimulus(0, 0, 1, 32'h40, 32'hDEADBEEF, 5'd0, 0, 2, 32'h0);
    applyStimulus(1, 1, 0, 32'h107, 32'h0, 5'd3, 0, 1, 32'h1234_5678);
    applyStimulus(1, 1, 0, 32'h3FE, 32'h0, 5'd11, 1, 4, 32'hAABB_CCDD);
    nop();
    checkOutput("bload2_ResultW", snap_result_w, 32'h0000_00BB);

    // Timeout
    applyStimulus(1, 1, 0, 32'h500, 32'h0, 5'd4, 0, 0, 32'h0);
    r_cnt = req_seen;
    nop();
    checkOutput("timeout_req_cycles", r_cnt, 16);
    checkOutput("timeout_MemErr", snap_mem_err, 1);
    checkOutput("timeout_ResultW", snap_result_w, 32'h0);
    nop();
    checkOutput("timeout_MemErr_sticky", snap_mem_err, 1);

    // Reset in the 2nd REQ cycle of a load, late ack afterwards
    p0 = rw_pulses;
    nextCycle();
    driveM(1, 1, 0, 32'h600, 32'h0, 5'd6, 0);
    dmem_bus.DmemRdata = 32'hFFFF_FFFF;
    exp_stall = 1; exp_req = 0;
    sampleBus();
    nextCycle();
    exp_stall = 1; exp_req = 1; exp_we = 0;
    exp_addr = 32'h600; exp_be = 4'hF; exp_wdata = 32'h0;
    sampleBus();
    nextCycle();
    rst = 1'b1; pend_rst = 1;
    sampleBus();
    nextCycle();
    rst = 1'b0;
    driveM(0, 0, 0, 0, 0, 0, 0);
    dmem_bus.DmemAck = 1'b1;
    exp_stall = 0; exp_req = 0;
    pend_w = 1; pend_rw = 0; pend_rd = 0; pend_res = 0;
    #1;
    checkOutput("rst_DmemReq", dmem_bus.DmemReq, 0);
    checkOutput("rst_StallM", StallM, 0);
    checkOutput("rst_MemErr", snap_mem_err, 0);
    nop();
    nop();
    checkOutput("rst_no_writeback", rw_pulses - p0, 0);

    // Recovery after reset
    applyStimulus(1, 0, 0, 32'hBEEF, 32'h0, 5'd10, 0, 0, 32'h0);
    nop();
    checkOutput("recover_ResultW", snap_result_w, 32'hBEEF);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory stage plus MEM/WB register, directly downstream of the Execute stage. Consumes the M-side outputs of the Execute pipeline register, performs loads and stores over a request/acknowledge data-memory port, and stalls the pipeline while an access is outstanding. Registers the writeback fields and drives `ResultW`, which feeds back to the Execute forwarding muxes and the register file.

## Interface
- `ACK_TIMEOUT`, 16: maximum cycles in REQ without `DmemAck` before the access is abandoned (range 1..255).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `RegWriteM`  in  1  instruction writes rd.
- `ResultSrcM`  in  1  1 = load; writeback takes memory data.
- `MemWriteM`  in  1  1 = store.
- `ALUResultM`  in  32  effective address, or ALU result for non-memory ops.
- `WriteDataM`  in  32  store data.
- `RdM`  in  5  destination register.
- `MemTypeM`  in  1  0 = word, 1 = byte (zero-extended load).
- `DmemReq`  out  1  access request; held until acknowledged.
- `DmemWe`  out  1  1 = write.
- `DmemAddr`  out  32  word-aligned address.
- `DmemWdata`  out  32  write data.
- `DmemBe`  out  4  byte enables.
- `DmemAck`  in  1  access complete; `DmemRdata` valid this cycle.
- `DmemRdata`  in  32  read data.
- `StallM`  out  1  hold M and all earlier stages.
- `RegWriteW`  out  1  registered write enable.
- `RdW`  out  5  registered destination.
- `ResultW`  out  32  `ResultSrcW ? ReadDataW : ALUResultW`; combinational from the W registers.
- `MemErr`  out  1  sticky: an access timed out.

## Operation
- Memory op = `MemWriteM | ResultSrcM`. If both are set, the op is a store and writeback is suppressed (`RegWriteW` = 0).
- FSM states: IDLE, REQ, DONE.
  - IDLE: memory op present → `StallM` = 1, latch address, data, type and direction, go to REQ. Non-memory op → no stall; W registers load the M fields at the edge.
  - REQ: `DmemReq` = 1 with the latched fields held stable; `StallM` = 1. On `DmemAck`, capture read data and go to DONE. When the timeout counter reaches `ACK_TIMEOUT`, set `MemErr`, use read data 0 and go to DONE.
  - DONE: `StallM` = 0, `DmemReq` = 0. W registers load (`ReadDataW` = formatted data) at the edge, then the FSM returns to IDLE.
- While `StallM` = 1, W registers load a bubble: `RegWriteW` = 0, other W fields unchanged.
- Address: `DmemAddr` = `{ALUResultM[31:2],2'b00}`. Misaligned word accesses are silently aligned; no trap.
- Word access: `DmemBe` = 4'b1111, `DmemWdata` = `WriteDataM`, load data = `DmemRdata`.
- Byte access (byte lane b = addr[1:0]):
  - `DmemBe` = `4'b0001 << b`.
  - `DmemWdata` = `{4{WriteDataM[7:0]}}`.
  - Load data = zero-extended `DmemRdata[8b+7:8b]`.
- `DmemAck` outside REQ is ignored.
- Timeout counter: cleared on entry to REQ; 8 bits wide.

## Timing
- Reset (any state, including mid-access): the FSM goes to IDLE; `DmemReq`, `DmemWe`, `StallM`, `RegWriteW`, `MemErr` = 0; `DmemAddr`, `DmemWdata`, `ResultW`, the W registers and the counter = 0; `DmemBe` = 0; `RdW` = 0. `DmemReq` drops at the reset edge.
- Non-memory op: 0 stall cycles; result visible on `ResultW` one edge later.
- Memory op with ack in the k-th REQ cycle (k ≥ 1): `StallM` is high for 1 + k cycles. The result appears on `ResultW` after the DONE edge, k + 2 edges after the op entered M.
- Timeout: REQ lasts exactly `ACK_TIMEOUT` cycles; `MemErr` rises at the edge leaving REQ.
- The upstream stage holds the M inputs stable while `StallM` = 1. The FSM samples them only in IDLE.
- Back-to-back memory ops: the second op enters M at the DONE edge and is detected in IDLE on the following cycle. There is no REQ overlap.

## Test plan
- ALU op (`RegWriteM`=1, `RdM`=5, `ALUResultM`=0x1234) → `StallM`=0; next cycle `RegWriteW`=1, `RdW`=5, `ResultW`=0x1234.
- Word load from addr 0x100, ack after 3 REQ cycles with rdata 0xCAFEBABE → `StallM` high 4 cycles; `DmemBe`=1111; `ResultW`=0xCAFEBABE; exactly one `RegWriteW` pulse.
- Byte store of 0xA5 to addr 0x203, ack in 1st REQ cycle → `DmemAddr`=0x200, `DmemBe`=1000, `DmemWdata`=0xA5A5A5A5, `RegWriteW`=0.
- Byte load from addr 0x301 with rdata 0x11F2_3344 → `ResultW`=0x00000033.
- Ack never arrives with `ACK_TIMEOUT`=16 → `DmemReq` high exactly 16 cycles; `MemErr`=1 and stays 1; `ResultW`=0.
- `rst` asserted in the 2nd REQ cycle → next cycle `DmemReq`=0, `StallM`=0, FSM in IDLE. A late `DmemAck` is ignored and there is no writeback.
